// File: rtl/ciaa_kbd_sequencer_pkg.sv
// Shared codes, state/source enums and the Amiga on-wire byte encoding for the keyboard sequencer.
// Honours KBD_POWERUP_SEQ_EN: when defined, the state set includes the power-up marker state.
package ciaa_kbd_sequencer_pkg;

    localparam logic [7:0] KC_LOST_SYNC   = 8'hF9;
    localparam logic [7:0] KC_OVERFLOW    = 8'hFA;
    localparam logic [7:0] KC_PWRUP_START = 8'hFD;
    localparam logic [7:0] KC_PWRUP_END   = 8'hFE;

`ifdef KBD_POWERUP_SEQ_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_RESYNC,
        ST_PWRUP
    } kbd_state_t;

    localparam kbd_state_t ST_RESET = ST_PWRUP;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_RESYNC
    } kbd_state_t;

    localparam kbd_state_t ST_RESET = ST_IDLE;
`endif

    // Where the byte currently on the wire came from, so the ack knows what to retire.
    typedef enum logic [1:0] {
        SRC_FIFO,
        SRC_OVF,
        SRC_PWRUP
    } kbd_src_t;

    // The keyboard shifts bit 6 first and bit 7 last, with active-low data.
    function automatic logic [7:0] wire_encode(input logic [7:0] b);
        return ~{b[6:0], b[7]};
    endfunction

endpackage

// File: rtl/ciaa_kbd_sequencer_fifo.sv
// Small clk7_en-qualified event FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module kbd_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk7_en,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (clk7_en && !reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/ciaa_kbd_sequencer.sv
// Buffers raw key events and feeds them to the CIA-A SDR with the Amiga ack/timeout/lost-sync handshake.
// Define KBD_POWERUP_SEQ_EN to send the 0xFD/0xFE power-up markers after reset.
module ciaa_kbd_sequencer
    import ciaa_kbd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1015000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk7_en,
    input  logic [7:0]                    keydat,
    input  logic                          keystrobe,
    output logic                          keyack,
    output logic [7:0]                    sp_dat,
    output logic                          sp_strobe,
    input  logic                          sp_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYC - 1);

    kbd_state_t  state;
    kbd_state_t  next_state;
    kbd_src_t    src;
    kbd_src_t    load_src;
    logic [19:0] timer;
    logic        ovf_pend;

    logic        push;
    logic        drop;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;

    logic        load_en;
    logic [7:0]  load_byte;
    logic        ovf_clear;
    logic        timer_clear;

`ifdef KBD_POWERUP_SEQ_EN
    logic [1:0]  pwr_idx;
    logic        pwr_adv;
`endif

    // keyack gates the next push so every accepted event gets exactly one ack pulse.
    assign push = keystrobe && !keyack;
    assign drop = push && fifo_full && !fifo_pop;

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clk7_en   (clk7_en),
        .push      (push),
        .push_data (keydat),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        next_state  = state;
        load_en     = 1'b0;
        load_byte   = KC_LOST_SYNC;
        load_src    = src;
        fifo_pop    = 1'b0;
        ovf_clear   = 1'b0;
        timer_clear = 1'b0;
`ifdef KBD_POWERUP_SEQ_EN
        pwr_adv     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (ovf_pend) begin
                    load_en    = 1'b1;
                    load_byte  = KC_OVERFLOW;
                    load_src   = SRC_OVF;
                    next_state = ST_SEND;
                end else if (!fifo_empty) begin
                    load_en    = 1'b1;
                    load_byte  = fifo_head;
                    load_src   = SRC_FIFO;
                    next_state = ST_SEND;
                end
            end
`ifdef KBD_POWERUP_SEQ_EN
            ST_PWRUP: begin
                load_en    = 1'b1;
                load_byte  = (pwr_idx == 2'd0) ? KC_PWRUP_START : KC_PWRUP_END;
                load_src   = SRC_PWRUP;
                next_state = ST_SEND;
            end
`endif
            ST_SEND: begin
                timer_clear = 1'b1;
                next_state  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (sp_ack) begin
                    next_state = ST_IDLE;
                    case (src)
                        SRC_FIFO: fifo_pop  = 1'b1;
                        SRC_OVF:  ovf_clear = 1'b1;
                        default: begin
`ifdef KBD_POWERUP_SEQ_EN
                            pwr_adv = 1'b1;
                            if (pwr_idx == 2'd0) begin
                                next_state = ST_PWRUP;
                            end
`endif
                        end
                    endcase
                end else if (timer == TIMEOUT_LAST) begin
                    load_en    = 1'b1;
                    next_state = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                // The 0xF9 strobe cycle behaves like SEND: restart the timer and ignore the ack line.
                if (sp_strobe) begin
                    timer_clear = 1'b1;
                end else if (sp_ack) begin
`ifdef KBD_POWERUP_SEQ_EN
                    next_state = (pwr_idx == 2'd2) ? ST_IDLE : ST_PWRUP;
`else
                    next_state = ST_IDLE;
`endif
                end else if (timer == TIMEOUT_LAST) begin
                    load_en = 1'b1;
                end
            end
            default: next_state = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state     <= ST_RESET;
                src       <= SRC_FIFO;
                timer     <= '0;
                ovf_pend  <= 1'b0;
                keyack    <= 1'b0;
                sp_strobe <= 1'b0;
                sp_dat    <= 8'hFF;
            end else begin
                state     <= next_state;
                keyack    <= push;
                sp_strobe <= load_en;
                if (load_en) begin
                    sp_dat <= wire_encode(load_byte);
                    src    <= load_src;
                end
                if (timer_clear) begin
                    timer <= '0;
                end else if (state == ST_WAIT_ACK || state == ST_RESYNC) begin
                    timer <= timer + 1'b1;
                end
                if (drop) begin
                    ovf_pend <= 1'b1;
                end else if (ovf_clear) begin
                    ovf_pend <= 1'b0;
                end
            end
        end
    end

`ifdef KBD_POWERUP_SEQ_EN
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                pwr_idx <= 2'd0;
            end else if (pwr_adv) begin
                pwr_idx <= pwr_idx + 2'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ciaa_kbd_sequencer.sv
// Randomised bench for ciaa_kbd_sequencer against a transaction-level handshake model, plus directed literal checks.
`timescale 1ns/1ps
module tb_ciaa_kbd_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 40;
`ifdef KBD_POWERUP_SEQ_EN
    localparam int PWR_N = 2;
`else
    localparam int PWR_N = 0;
`endif
    localparam int K_FIFO = 0;
    localparam int K_OVF  = 1;
    localparam int K_PWR  = 2;
    localparam int K_SYNC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk7_en = 1'b0;
    logic [7:0] keydat = 8'h00;
    logic       keystrobe = 1'b0;
    logic       sp_ack = 1'b0;
    logic       keyack;
    logic [7:0] sp_dat;
    logic       sp_strobe;
    logic [3:0] fifo_level;

    ciaa_kbd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk7_en    (clk7_en),
        .keydat     (keydat),
        .keystrobe  (keystrobe),
        .keyack     (keyack),
        .sp_dat     (sp_dat),
        .sp_strobe  (sp_strobe),
        .sp_ack     (sp_ack),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Model: a queue of stored events, the overflow flag, the pending power-up count and the byte on the wire.
    int         q[$];
    bit         m_ovf = 1'b0;
    int         m_pwr = 0;
    bit         m_busy = 1'b0;
    int         m_kind = 0;
    int         m_strobe_cyc = 0;
    int         m_n = 0;
    bit         m_keyack = 1'b0;
    bit         m_strobe = 1'b0;
    logic [7:0] m_dat = 8'hFF;

    function automatic logic [7:0] enc(input logic [7:0] b);
        logic [7:0] r;
        r = {b[6:0], b[7]};
        return ~r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (enabled cycle %0d)", name, act, exp, m_n);
        end
    endtask

    task automatic model_step(input bit rst, input bit ks, input logic [7:0] kd, input bit ack);
        bit         pop;
        bit         push;
        bit         pick;
        bit         nstrobe;
        logic [7:0] ndat;
        logic [7:0] b;
        if (rst) begin
            q.delete();
            m_ovf    = 1'b0;
            m_pwr    = PWR_N;
            m_busy   = 1'b0;
            m_keyack = 1'b0;
            m_strobe = 1'b0;
            m_dat    = 8'hFF;
            m_n++;
            return;
        end
        pop = 1'b0; pick = 1'b0; nstrobe = 1'b0; ndat = m_dat; b = 8'h00;
        if (m_busy) begin
            if (m_n > m_strobe_cyc && ack) begin
                case (m_kind)
                    K_FIFO:  pop = 1'b1;
                    K_OVF:   m_ovf = 1'b0;
                    K_PWR:   m_pwr--;
                    default: ;
                endcase
                m_busy = 1'b0;
            end else if (m_n == m_strobe_cyc + TMO) begin
                nstrobe      = 1'b1;
                ndat         = enc(8'hF9);
                m_kind       = K_SYNC;
                m_strobe_cyc = m_n + 1;
            end
        end else begin
            if (m_pwr > 0) begin
                pick = 1'b1; b = (m_pwr == 2) ? 8'hFD : 8'hFE; m_kind = K_PWR;
            end else if (m_ovf) begin
                pick = 1'b1; b = 8'hFA; m_kind = K_OVF;
            end else if (q.size() > 0) begin
                pick = 1'b1; b = 8'(q[0]); m_kind = K_FIFO;
            end
            if (pick) begin
                m_busy       = 1'b1;
                m_strobe_cyc = m_n + 1;
                nstrobe      = 1'b1;
                ndat         = enc(b);
            end
        end
        push = ks && !m_keyack;
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(int'(kd));
            else m_ovf = 1'b1;
        end
        m_keyack = push;
        m_strobe = nstrobe;
        m_dat    = ndat;
        m_n++;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check_output("keyack", 32'(keyack), 32'(m_keyack));
            check_output("sp_strobe", 32'(sp_strobe), 32'(m_strobe));
            check_output("sp_dat", 32'(sp_dat), 32'(m_dat));
            check_output("fifo_level", 32'(fifo_level), 32'(q.size()));
        end
    end

    task automatic apply_stimulus(input bit en, input bit rst, input bit ks, input logic [7:0] kd, input bit ack);
        clk7_en   = en;
        reset     = rst;
        keystrobe = ks;
        keydat    = kd;
        sp_ack    = ack;
        @(posedge clk);
        if (en) model_step(rst, ks, kd, ack);
        #1;
    endtask

    task automatic cyc(input bit ks, input logic [7:0] kd, input bit ack);
        apply_stimulus(1'b1, 1'b0, ks, kd, ack);
    endtask

    task automatic ack_byte();
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic wait_strobe(input string name);
        int k;
        k = 0;
        while (sp_strobe !== 1'b1 && k < 4 * TMO) begin
            cyc(1'b0, 8'h00, 1'b0);
            k++;
        end
        if (sp_strobe !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL %s: sp_strobe not seen within %0d cycles", name, 4 * TMO);
        end
    endtask

    task automatic reset_dut();
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checking = 1'b1;
        check_output("reset_keyack", 32'(keyack), 32'h0);
        check_output("reset_strobe", 32'(sp_strobe), 32'h0);
        check_output("reset_dat", 32'(sp_dat), 32'hFF);
        check_output("reset_level", 32'(fifo_level), 32'h0);
    endtask

    task automatic pwrup_check();
`ifdef KBD_POWERUP_SEQ_EN
        wait_strobe("pwrup_start");
        check_output("pwrup_start_dat", 32'(sp_dat), 32'h04);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        wait_strobe("pwrup_end");
        check_output("pwrup_end_dat", 32'(sp_dat), 32'h02);
        ack_byte();
        wait_strobe("pwrup_key");
        check_output("pwrup_key_dat", 32'(sp_dat), 32'hDD);
        ack_byte();
`endif
    endtask

    initial begin
        int ack_pct;
        logic [7:0] exp_list [8];

        $display("[TB] start");
        reset_dut();
        pwrup_check();

        // Single key and its up-stroke.
        cyc(1'b1, 8'h20, 1'b0);
        check_output("single_keyack", 32'(keyack), 32'h1);
        check_output("single_no_early_strobe", 32'(sp_strobe), 32'h0);
        cyc(1'b0, 8'h00, 1'b0);
        check_output("single_strobe", 32'(sp_strobe), 32'h1);
        check_output("single_dat", 32'(sp_dat), 32'hBF);
        ack_byte();
        check_output("single_level_after_ack", 32'(fifo_level), 32'h0);
        cyc(1'b1, 8'hA0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check_output("upstroke_strobe", 32'(sp_strobe), 32'h1);
        check_output("upstroke_dat", 32'(sp_dat), 32'hBE);
        ack_byte();

        // Timeout, lost-sync and resend.
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check_output("timeout_first_dat", 32'(sp_dat), 32'hBF);
        for (int i = 0; i <= TMO; i++) cyc(1'b0, 8'h00, 1'b0);
        check_output("timeout_sync_strobe", 32'(sp_strobe), 32'h1);
        check_output("timeout_sync_dat", 32'(sp_dat), 32'h0C);
        ack_byte();
        wait_strobe("timeout_resend");
        check_output("timeout_resend_dat", 32'(sp_dat), 32'hBF);
        ack_byte();
        check_output("timeout_level", 32'(fifo_level), 32'h0);

        // Overflow with the first byte in flight.
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            cyc(1'b1, 8'(8'h30 + i), 1'b0);
            check_output("ovf_keyack", 32'(keyack), 32'h1);
            cyc(1'b0, 8'h00, 1'b0);
        end
        check_output("ovf_level_full", 32'(fifo_level), 32'(DEPTH));
        ack_byte();
        wait_strobe("ovf_code");
        check_output("ovf_code_dat", 32'(sp_dat), 32'h0A);
        ack_byte();
        for (int i = 0; i < DEPTH - 1; i++) begin
            wait_strobe("ovf_drain");
            check_output("ovf_drain_dat", 32'(sp_dat), 32'(enc(8'(8'h30 + i))));
            ack_byte();
        end
        check_output("ovf_level_empty", 32'(fifo_level), 32'h0);

        // Push and pop in the same cycle while full.
        cyc(1'b1, 8'h40, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1'b1, 8'(8'h40 + i), 1'b0);
            cyc(1'b0, 8'h00, 1'b0);
        end
        check_output("pp_level_full", 32'(fifo_level), 32'(DEPTH));
        cyc(1'b1, 8'h55, 1'b1);
        check_output("pp_level_same", 32'(fifo_level), 32'(DEPTH));
        for (int i = 0; i < DEPTH - 1; i++) exp_list[i] = 8'(8'h41 + i);
        exp_list[DEPTH-1] = 8'h55;
        for (int i = 0; i < DEPTH; i++) begin
            wait_strobe("pp_drain");
            check_output("pp_drain_dat", 32'(sp_dat), 32'(enc(exp_list[i])));
            ack_byte();
        end
        check_output("pp_level_empty", 32'(fifo_level), 32'h0);

        // Reset with three entries buffered and one in flight.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'(8'h61 + i), 1'b0);
            cyc(1'b0, 8'h00, 1'b0);
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check_output("midreset_level", 32'(fifo_level), 32'h0);
        check_output("midreset_dat", 32'(sp_dat), 32'hFF);
        check_output("midreset_strobe", 32'(sp_strobe), 32'h0);
        pwrup_check();
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b0);

        // Randomised traffic with stalls, varying ack behaviour and occasional resets.
        for (int c = 0; c < 15; c++) begin
            case ($urandom_range(0, 3))
                0:       ack_pct = 0;
                1:       ack_pct = 5;
                2:       ack_pct = 30;
                default: ack_pct = 60;
            endcase
            for (int i = 0; i < 200; i++) begin
                apply_stimulus(($urandom_range(0, 3) != 0),
                               ($urandom_range(0, 599) == 0),
                               ($urandom_range(0, 1) == 1),
                               8'($urandom_range(0, 255)),
                               ($urandom_range(0, 99) < ack_pct));
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
